// File: rtl/instr_mem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes one word per instruction into instruction memory.
// Optional LOADER_CHECKSUM_EN: a trailing XOR checksum byte, reported on csum_ok/csum_err.
module instr_mem_loader #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [ADDRESS_WIDTH-2:0] len_words,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     cpu_stall,
`ifdef LOADER_CHECKSUM_EN
  output logic                     csum_err,
  output logic                     csum_ok,
`endif
  output logic                     done
);

  localparam int LW = ADDRESS_WIDTH - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH-1:0] base_q;
  logic [LW-1:0]            len_q;
  logic [LW-1:0]            word_idx_q;
  logic [1:0]               byte_cnt_q;
  logic                     byte_ready_q;
  logic                     wr_en_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]    wr_data_q;
  logic                     cpu_stall_q;
  logic                     done_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]               csum_q;
  logic                     csum_ok_q;
  logic                     csum_err_q;
`endif

  logic [LW-1:0]            word_idx_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_d;
  logic [ADDRESS_WIDTH-1:0] base_d;
  logic                     last_word;
  logic                     byte_fire;

  assign word_idx_d = word_idx_q + LW'(1);
  assign last_word  = (word_idx_d == len_q);
  assign byte_fire  = byte_valid && byte_ready_q;
  assign base_d     = base_addr & {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};
  // Byte offset of the word; the carry out of the top bit is dropped so addresses wrap.
  assign wr_addr_d  = base_q + {word_idx_q[LW-2:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_cnt_q   <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_stall_q  <= 1'b0;
      done_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
      csum_ok_q    <= 1'b0;
      csum_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            base_q     <= base_d;
            len_q      <= len_words;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
            csum_ok_q  <= (len_words == '0);
            csum_err_q <= 1'b0;
`endif
            if (len_words == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= S_COLLECT;
              done_q       <= 1'b0;
              byte_ready_q <= 1'b1;
              cpu_stall_q  <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (byte_fire) begin
            wr_data_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data;
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ byte_data;
`endif
            if (byte_cnt_q == 2'd3) begin
              state_q      <= S_WRITE;
              byte_ready_q <= 1'b0;
              wr_en_q      <= 1'b1;
              wr_addr_q    <= wr_addr_d;
            end
          end
        end
        S_WRITE: begin
          wr_en_q    <= 1'b0;
          word_idx_q <= word_idx_d;
          if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
            state_q      <= S_CHECK;
            byte_ready_q <= 1'b1;
`else
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            cpu_stall_q <= 1'b0;
`endif
          end else begin
            state_q      <= S_COLLECT;
            byte_ready_q <= 1'b1;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (byte_fire) begin
            csum_ok_q    <= (byte_data == csum_q);
            csum_err_q   <= (byte_data != csum_q);
            state_q      <= S_DONE;
            done_q       <= 1'b1;
            byte_ready_q <= 1'b0;
            cpu_stall_q  <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_stall  = cpu_stall_q;
  assign done       = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign csum_ok    = csum_ok_q;
  assign csum_err   = csum_err_q;
`endif

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: the fetch path only reads it by PC; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Issues one word write per instruction into the instruction memory write port.
- Holds the CPU stalled while loading and asserts done when the program is in place.

Parameters:
ADDRESS_WIDTH, 8, byte address width of instruction memory (PC width)
DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle load request; honoured only in IDLE or DONE
base_addr  input  ADDRESS_WIDTH  byte address of first word, latched on start; bits [1:0] forced to 0
len_words  input  ADDRESS_WIDTH-1  number of words to load, latched on start
byte_valid  input  1  byte_data valid
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  instruction memory write strobe, one cycle per word
wr_addr  output  ADDRESS_WIDTH  word-aligned byte address of the write
wr_data  output  DATA_WIDTH  assembled instruction word
cpu_stall  output  1  high while loading; CPU must not advance PC
done  output  1  high in DONE state

Behaviour:
- Reset: state=IDLE. byte_ready, wr_en, cpu_stall and done are 0. wr_addr, wr_data, byte counter and word counter are 0.
- IDLE:
  - byte_ready=0, cpu_stall=0.
  - On start: latch base_addr (low 2 bits cleared) and len_words, clear the counters.
  - If len_words==0, go to DONE; otherwise go to COLLECT.
- COLLECT:
  - byte_ready=1, cpu_stall=1.
  - A byte transfers when byte_valid&&byte_ready. Byte k (k=0..3) is placed in wr_data[8k+7:8k].
  - byte_valid low leaves all state unchanged.
  - After the 4th accepted byte, go to WRITE the next cycle.
- WRITE:
  - One cycle only. wr_en=1, byte_ready=0, cpu_stall=1.
  - wr_addr = latched base + 4*word_idx, truncated to ADDRESS_WIDTH, so addresses wrap modulo 2^ADDRESS_WIDTH.
  - Then word_idx++. Go to DONE if word_idx+1==len_words, else return to COLLECT.
- DONE:
  - done=1, cpu_stall=0, byte_ready=0.
  - Stays in DONE until start, which behaves exactly as start in IDLE.
- Latency: 4th byte accepted in cycle N gives wr_en in cycle N+1. The earliest next byte is accepted in N+2.
- Throughput: max one word per 5 cycles.
- start while in COLLECT or WRITE: ignored; latched values unchanged.
- Byte stream idle mid-word: partial word retained indefinitely, no timeout.
- Bytes offered in IDLE, WRITE or DONE: not accepted (byte_ready=0); the sender must hold them.
- Reset mid-load: immediate return to IDLE. The partial word is discarded, no wr_en is issued and cpu_stall drops the following cycle.
- Outputs are registered. wr_addr and wr_data hold their last values outside WRITE.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - Adds a CHECK state between the final WRITE and DONE, plus outputs csum_err (1 bit) and csum_ok (1 bit).
  - A running 8-bit XOR of all accepted data bytes is kept; it is cleared on start.
  - In CHECK: byte_ready=1, cpu_stall=1. One trailing byte is accepted and compared with the running XOR.
  - On a match, csum_ok=1; otherwise csum_err=1. The flag is held through DONE and cleared on start or reset.
  - len_words==0 still goes directly to DONE, with csum_ok=1.
- Undefined: no CHECK state, no csum ports; the last WRITE goes straight to DONE.

Test Plan:
- Basic load: start, base=0x00, len=2, bytes 13 00 00 00 93 00 10 00 with valid always high.
  - Required: wr_en pulses with (0x00, 0x00000013) and (0x04, 0x00100093).
  - Required: done=1; cpu_stall high from the cycle after start until DONE.
- Gapped stream: same stimulus with byte_valid low on alternate cycles.
  - Required: identical writes and data; byte counter does not advance on gaps.
- Wrap: base=0xFC, len=2.
  - Required: writes at 0xFC then 0x00.
  - Required: base=0xFE latches as 0xFC.
- Edge cases:
  - len=0 → DONE one cycle after start, no wr_en.
  - start pulsed during COLLECT → ignored; load completes with the original len.
- Reset mid-op: rst after 2 bytes of word 1.
  - Required: IDLE, no wr_en, cpu_stall=0.
  - Required: a subsequent full load of len=1 writes the correct word at base.
- Checksum (LOADER_CHECKSUM_EN): bytes 13 00 00 00, then trailer.
  - Trailer 0x13 → csum_ok=1.
  - Trailer 0x12 → csum_err=1.
